// File: rtl/dbus_uncached_responder_if.sv
// CPU DBus request/response signals plus the single-beat AXI-lite memory channels.
// slave is the responder's view; master is the CPU-and-memory side that drives it.
interface dbus_uncached_responder_if;
  logic        req;
  logic        wr;
  logic [2:0]  size;
  logic [3:0]  wstrb;
  logic [3:0]  offset;
  logic [7:0]  index;
  logic [19:0] tag;
  logic [31:0] wdata;
  logic        tlb_ex;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        bus_err;

  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata_m;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata_m;
  logic [3:0]  wstrb_m;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport slave (
    input  req, wr, size, wstrb, offset, index, tag, wdata, tlb_ex,
    output addr_ok, data_ok, rdata, bus_err,
    output araddr, arsize, arvalid, input arready,
    input  rdata_m, rresp, rvalid, output rready,
    output awaddr, awsize, awvalid, input awready,
    output wdata_m, wstrb_m, wvalid, input wready,
    input  bresp, bvalid, output bready
  );

  modport master (
    output req, wr, size, wstrb, offset, index, tag, wdata, tlb_ex,
    input  addr_ok, data_ok, rdata, bus_err,
    input  araddr, arsize, arvalid, output arready,
    output rdata_m, rresp, rvalid, input rready,
    input  awaddr, awsize, awvalid, output awready,
    input  wdata_m, wstrb_m, wvalid, output wready,
    output bresp, bvalid, input bready
  );
endinterface

// File: rtl/dbus_uncached_responder.sv
// Uncached DBus responder: one outstanding load/store mapped to a single AXI-lite beat.
// Accepts in the IDLE cycle (addr_ok combinational); stalls on bus readiness, watchdog forces error completion.
module dbus_uncached_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] RESET_RDATA    = 32'h0
) (
  input logic clk,
  input logic reset,
  dbus_uncached_responder_if.slave bus
);

  typedef enum logic [2:0] {IDLE, EX_DONE, RD_A, RD_D, WR_AW, WR_B, RESP} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  wstrb_q;
  logic [1:0]  size_q;
  logic        wr_q, aw_done, w_done, err_q, absorb_q;
  logic [7:0]  wd_cnt;

  logic accept, busy, timeout, aw_fin, w_fin, abandon;
  logic unused_bits;

  assign unused_bits = ^{bus.size[2], bus.rresp[0], bus.bresp[0]};

  assign accept = (state == IDLE) && bus.req && !reset;
  assign busy   = (state == RD_A) || (state == RD_D) || (state == WR_AW) || (state == WR_B);
  // >= rather than == so a handshake landing on the limit cycle still leaves the next phase guarded
  assign timeout = busy && (TIMEOUT_CYCLES != 0) && (wd_cnt >= 8'(TIMEOUT_CYCLES - 1));
  assign aw_fin  = aw_done || bus.awready;
  assign w_fin   = w_done || bus.wready;
  assign abandon = timeout && (((state == RD_A)  && !bus.arready) ||
                               ((state == RD_D)  && !bus.rvalid)  ||
                               ((state == WR_AW) && !(aw_fin && w_fin)) ||
                               ((state == WR_B)  && !bus.bvalid));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = bus.tlb_ex ? EX_DONE : (bus.wr ? WR_AW : RD_A);
      EX_DONE: state_nxt = IDLE;
      RD_A:    if (bus.arready) state_nxt = RD_D;
               else if (abandon) state_nxt = RESP;
      RD_D:    if (bus.rvalid || abandon) state_nxt = RESP;
      WR_AW:   if (aw_fin && w_fin) state_nxt = WR_B;
               else if (abandon) state_nxt = RESP;
      WR_B:    if (bus.bvalid || abandon) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.addr_ok = accept;
    bus.data_ok = (state == EX_DONE) || (state == RESP);
    bus.rdata   = rdata_q;
    bus.bus_err = err_q && bus.data_ok;
    bus.araddr  = addr_q;
    bus.arsize  = {1'b0, size_q};
    bus.arvalid = (state == RD_A);
    // after an abandoned transfer the ready stays up through RESP to swallow a straggling beat
    bus.rready  = (state == RD_D) || (absorb_q && !wr_q);
    bus.awaddr  = addr_q;
    bus.awsize  = {1'b0, size_q};
    bus.awvalid = (state == WR_AW) && !aw_done;
    bus.wdata_m = wdata_q;
    bus.wstrb_m = wstrb_q;
    bus.wvalid  = (state == WR_AW) && !w_done;
    bus.bready  = (state == WR_B) || (absorb_q && wr_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      size_q   <= '0;
      wr_q     <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      err_q    <= 1'b0;
      absorb_q <= 1'b0;
      wd_cnt   <= '0;
      rdata_q  <= RESET_RDATA;
    end else begin
      absorb_q <= abandon;
      if (state == IDLE)               wd_cnt <= '0;
      else if (busy && wd_cnt != 8'hFF) wd_cnt <= wd_cnt + 8'd1;

      if (accept) begin
        addr_q  <= {bus.tag, bus.index, bus.offset};
        wdata_q <= bus.wdata;
        wstrb_q <= bus.wstrb;
        size_q  <= bus.size[1:0];
        wr_q    <= bus.wr;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        if (bus.tlb_ex) begin
          rdata_q <= RESET_RDATA;
          err_q   <= 1'b0;
        end
      end

      if (state == WR_AW) begin
        if (bus.awready) aw_done <= 1'b1;
        if (bus.wready)  w_done  <= 1'b1;
      end

      if (abandon) begin
        rdata_q <= RESET_RDATA;
        err_q   <= 1'b1;
      end else if ((state == RD_D) && bus.rvalid) begin
        rdata_q <= bus.rdata_m;
        err_q   <= bus.rresp[1];
      end else if ((state == WR_B) && bus.bvalid) begin
        rdata_q <= RESET_RDATA;
        err_q   <= bus.bresp[1];
      end
    end
  end

endmodule

// File: tb/tb_dbus_uncached_responder.sv
// Directed bench for dbus_uncached_responder: a transaction table plus hand sequences for
// split write handshakes, back-to-back acceptance and mid-transfer reset.
module tb_dbus_uncached_responder;

  localparam logic [31:0] RST_RD = 32'hBAD0_BAD0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dbus_uncached_responder_if ifc ();

  dbus_uncached_responder #(.TIMEOUT_CYCLES(8), .RESET_RDATA(RST_RD)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (ifc.slave)
  );

  // memory model knobs and state
  int          ar_lat, aw_lat, w_lat;
  logic        ar_stuck, r_hold;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_resp;
  int          ar_wait, aw_wait, w_wait;
  logic        r_pend, b_pend, aw_seen, w_seen;

  assign ifc.arready = ifc.arvalid && !ar_stuck && (ar_wait >= ar_lat);
  assign ifc.awready = ifc.awvalid && (aw_wait >= aw_lat);
  assign ifc.wready  = ifc.wvalid && (w_wait >= w_lat);
  assign ifc.rvalid  = r_pend && !r_hold;
  assign ifc.rdata_m = mem_rdata;
  assign ifc.rresp   = mem_resp;
  assign ifc.bresp   = mem_resp;
  assign ifc.bvalid  = b_pend;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ar_wait <= 0; aw_wait <= 0; w_wait <= 0;
      r_pend <= 1'b0; b_pend <= 1'b0; aw_seen <= 1'b0; w_seen <= 1'b0;
    end else begin
      ar_wait <= (ifc.arvalid && !ifc.arready) ? ar_wait + 1 : 0;
      aw_wait <= (ifc.awvalid && !ifc.awready) ? aw_wait + 1 : 0;
      w_wait  <= (ifc.wvalid && !ifc.wready) ? w_wait + 1 : 0;
      if (ifc.arvalid && ifc.arready) r_pend <= 1'b1;
      else if (ifc.rvalid && ifc.rready) r_pend <= 1'b0;
      if (ifc.bvalid && ifc.bready) begin
        b_pend <= 1'b0;
      end else if ((aw_seen || (ifc.awvalid && ifc.awready)) &&
                   (w_seen || (ifc.wvalid && ifc.wready)) && !b_pend) begin
        b_pend <= 1'b1; aw_seen <= 1'b0; w_seen <= 1'b0;
      end else begin
        if (ifc.awvalid && ifc.awready) aw_seen <= 1'b1;
        if (ifc.wvalid && ifc.wready)   w_seen  <= 1'b1;
      end
    end
  end

  typedef struct {
    logic        wr;
    logic        tlb_ex;
    logic [2:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ar_lat, aw_lat, w_lat;
    logic        stuck;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_resp;
    int          exp_lat;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic        exp_bus;
    logic [2:0]  exp_size;
    logic        exp_rr;
  } vec_t;

  vec_t vt[12];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", what, act, exp);
    end
  endtask

  task automatic set_mem(input int a, input int aw, input int w, input logic stuck,
                         input logic hold, input logic [31:0] rd, input logic [1:0] resp);
    ar_lat = a; aw_lat = aw; w_lat = w; ar_stuck = stuck; r_hold = hold;
    mem_rdata = rd; mem_resp = resp;
  endtask

  task automatic drive_req(input logic wr, input logic tlb, input logic [2:0] size,
                           input logic [3:0] strb, input logic [31:0] addr, input logic [31:0] wd);
    ifc.req = 1'b1; ifc.wr = wr; ifc.tlb_ex = tlb; ifc.size = size; ifc.wstrb = strb;
    ifc.tag = addr[31:12]; ifc.index = addr[11:4]; ifc.offset = addr[3:0]; ifc.wdata = wd;
  endtask

  task automatic clear_req();
    ifc.req = 1'b0; ifc.wr = 1'b0; ifc.tlb_ex = 1'b0; ifc.size = 3'd0; ifc.wstrb = 4'd0;
    ifc.tag = '0; ifc.index = '0; ifc.offset = '0; ifc.wdata = '0;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int n; logic got, bus_seen, rr_done, err_done;
    logic [31:0] a_seen, wd_seen, rd_done; logic [2:0] s_seen; logic [3:0] st_seen;
    set_mem(v.ar_lat, v.aw_lat, v.w_lat, v.stuck, 1'b0, v.mem_rdata, v.mem_resp);
    @(negedge clk);
    drive_req(v.wr, v.tlb_ex, v.size, v.wstrb, v.addr, v.wdata);
    #1 check({nm, " addr_ok"}, 32'(ifc.addr_ok), 32'd1);
    @(posedge clk);
    #1 clear_req();
    n = 0; got = 0; bus_seen = 0; rr_done = 0; err_done = 0;
    a_seen = '0; wd_seen = '0; rd_done = '0; s_seen = '0; st_seen = '0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (ifc.arvalid) begin bus_seen = 1; a_seen = ifc.araddr; s_seen = ifc.arsize; end
      if (ifc.awvalid) begin bus_seen = 1; a_seen = ifc.awaddr; s_seen = ifc.awsize; end
      if (ifc.wvalid)  begin bus_seen = 1; st_seen = ifc.wstrb_m; wd_seen = ifc.wdata_m; end
      if (ifc.data_ok) begin
        got = 1; rd_done = ifc.rdata; err_done = ifc.bus_err; rr_done = ifc.rready;
      end
    end
    check({nm, " latency"}, 32'(n), 32'(v.exp_lat));
    check({nm, " bus_err"}, 32'(err_done), 32'(v.exp_err));
    check({nm, " bus_activity"}, 32'(bus_seen), 32'(v.exp_bus));
    check({nm, " rready_at_done"}, 32'(rr_done), 32'(v.exp_rr));
    if (!v.wr || v.tlb_ex) check({nm, " rdata"}, rd_done, v.exp_rdata);
    if (v.exp_bus) begin
      check({nm, " addr"}, a_seen, v.addr);
      check({nm, " size"}, 32'(s_seen), 32'(v.exp_size));
    end
    if (v.wr && v.exp_bus) begin
      check({nm, " wstrb_m"}, 32'(st_seen), 32'(v.wstrb));
      check({nm, " wdata_m"}, wd_seen, v.wdata);
    end
    @(negedge clk);
    check({nm, " single_pulse"}, 32'(ifc.data_ok), 32'd0);
  endtask

  task automatic wait_done(input string nm, output int n);
    n = 0;
    while (!ifc.data_ok && n < 40) begin @(negedge clk); n++; end
    if (!ifc.data_ok) begin n_cmp++; n_bad++; $display("FAIL %s: no data_ok within 40 cycles", nm); end
  endtask

  initial begin
    int n;
    logic [8:0] ao_bits, do_bits, awv_bits, wv_bits, br_bits;
    logic [3:0] strb_cap; logic [31:0] wd_cap;

    vt[0]  = '{1'b0, 1'b0, 3'd2, 4'h0, 32'h1FC00004, 32'h0, 0, 0, 0, 1'b0, 32'hDEADBEEF, 2'b00, 3, 1'b0, 32'hDEADBEEF, 1'b1, 3'd2, 1'b0};
    vt[1]  = '{1'b0, 1'b0, 3'd0, 4'h0, 32'h12345A53, 32'h0, 2, 0, 0, 1'b0, 32'h0000007E, 2'b00, 5, 1'b0, 32'h0000007E, 1'b1, 3'd0, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 3'd5, 4'h0, 32'h80000012, 32'h0, 0, 0, 0, 1'b0, 32'h0000BEEF, 2'b00, 3, 1'b0, 32'h0000BEEF, 1'b1, 3'd1, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 3'd2, 4'h0, 32'h00000100, 32'h0, 0, 0, 0, 1'b0, 32'h11112222, 2'b10, 3, 1'b1, 32'h11112222, 1'b1, 3'd2, 1'b0};
    vt[4]  = '{1'b0, 1'b0, 3'd2, 4'h0, 32'h00000200, 32'h0, 0, 0, 0, 1'b0, 32'h33334444, 2'b11, 3, 1'b1, 32'h33334444, 1'b1, 3'd2, 1'b0};
    vt[5]  = '{1'b0, 1'b0, 3'd2, 4'h0, 32'h00000300, 32'h0, 0, 0, 0, 1'b0, 32'h55556666, 2'b01, 3, 1'b0, 32'h55556666, 1'b1, 3'd2, 1'b0};
    vt[6]  = '{1'b1, 1'b0, 3'd2, 4'hF, 32'hA0001000, 32'hCAFEF00D, 0, 0, 0, 1'b0, 32'h0, 2'b00, 3, 1'b0, RST_RD, 1'b1, 3'd2, 1'b0};
    vt[7]  = '{1'b1, 1'b0, 3'd1, 4'h3, 32'hA0001002, 32'h0000BEEF, 0, 0, 2, 1'b0, 32'h0, 2'b10, 5, 1'b1, RST_RD, 1'b1, 3'd1, 1'b0};
    vt[8]  = '{1'b1, 1'b0, 3'd2, 4'hF, 32'hA0001008, 32'h01234567, 0, 3, 0, 1'b0, 32'h0, 2'b00, 6, 1'b0, RST_RD, 1'b1, 3'd2, 1'b0};
    vt[9]  = '{1'b0, 1'b0, 3'd2, 4'h0, 32'h1FC00010, 32'h0, 0, 0, 0, 1'b1, 32'h0, 2'b00, 9, 1'b1, RST_RD, 1'b1, 3'd2, 1'b1};
    vt[10] = '{1'b0, 1'b1, 3'd2, 4'h0, 32'h00000040, 32'h0, 0, 0, 0, 1'b0, 32'hFFFFFFFF, 2'b00, 1, 1'b0, RST_RD, 1'b0, 3'd2, 1'b0};
    vt[11] = '{1'b1, 1'b1, 3'd2, 4'hF, 32'h00000044, 32'h12341234, 0, 0, 0, 1'b0, 32'h0, 2'b00, 1, 1'b0, RST_RD, 1'b0, 3'd2, 1'b0};

    clear_req();
    set_mem(0, 0, 0, 1'b0, 1'b0, 32'h0, 2'b00);
    ifc.req = 1'b1;
    repeat (2) @(negedge clk);
    check("reset addr_ok", 32'(ifc.addr_ok), 32'd0);
    check("reset data_ok", 32'(ifc.data_ok), 32'd0);
    check("reset valids", {28'd0, ifc.arvalid, ifc.awvalid, ifc.wvalid, ifc.bus_err}, 32'd0);
    check("reset readys", {30'd0, ifc.rready, ifc.bready}, 32'd0);
    check("reset rdata", ifc.rdata, RST_RD);
    check("reset araddr", ifc.araddr, 32'd0);
    ifc.req = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // store byte with AW accepted two cycles ahead of W
    set_mem(0, 1, 3, 1'b0, 1'b0, 32'h0, 2'b00);
    @(negedge clk);
    drive_req(1'b1, 1'b0, 3'd0, 4'b0100, 32'hBFD00008, 32'h00AB0000);
    @(posedge clk); #1 clear_req();
    awv_bits = '0; wv_bits = '0; do_bits = '0; br_bits = '0; strb_cap = '0; wd_cap = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      awv_bits[c] = ifc.awvalid; wv_bits[c] = ifc.wvalid;
      do_bits[c] = ifc.data_ok; br_bits[c] = ifc.bready;
      if (c == 1) begin strb_cap = ifc.wstrb_m; wd_cap = ifc.wdata_m; end
    end
    check("split_wr awvalid", 32'(awv_bits), 32'(9'b0_0000_0110));
    check("split_wr wvalid", 32'(wv_bits), 32'(9'b0_0001_1110));
    check("split_wr bready", 32'(br_bits), 32'(9'b0_0010_0000));
    check("split_wr data_ok", 32'(do_bits), 32'(9'b0_0100_0000));
    check("split_wr wstrb_m", 32'(strb_cap), 32'(4'b0100));
    check("split_wr wdata_m", wd_cap, 32'h00AB0000);

    // two loads with req held high throughout
    set_mem(0, 0, 0, 1'b0, 1'b0, 32'hA5A5A5A5, 2'b00);
    @(negedge clk);
    drive_req(1'b0, 1'b0, 3'd2, 4'h0, 32'h00001000, 32'h0);
    ao_bits = '0; do_bits = '0;
    #1 ao_bits[0] = ifc.addr_ok;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      ao_bits[c] = ifc.addr_ok; do_bits[c] = ifc.data_ok;
    end
    check("b2b addr_ok", 32'(ao_bits), 32'(9'b0_0001_0001));
    check("b2b data_ok", 32'(do_bits), 32'(9'b0_0000_1000));
    @(posedge clk); #1 clear_req();
    @(negedge clk);
    wait_done("b2b second", n);
    check("b2b second latency", 32'(n + 1), 32'd3);
    check("b2b second rdata", ifc.rdata, 32'hA5A5A5A5);

    // reset while waiting for read data
    set_mem(0, 0, 0, 1'b0, 1'b1, 32'h77777777, 2'b00);
    @(negedge clk);
    drive_req(1'b0, 1'b0, 3'd2, 4'h0, 32'h00002000, 32'h0);
    @(posedge clk); #1 clear_req();
    repeat (2) @(negedge clk);
    check("mid_reset rready before", 32'(ifc.rready), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_reset rready", 32'(ifc.rready), 32'd0);
    check("mid_reset data_ok", 32'(ifc.data_ok), 32'd0);
    check("mid_reset rdata", ifc.rdata, RST_RD);
    @(negedge clk);
    rst = 1'b0; r_hold = 1'b0;
    do_bits = '0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      do_bits[c] = ifc.data_ok;
    end
    check("mid_reset no data_ok", 32'(do_bits), 32'd0);
    run_vec(vt[0], "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench still running at %0t, required finish", $time);
    $fatal(1);
  end

endmodule
